collision_pair_scheduler: RTL and testbench
===========================================

Name: collision_pair_scheduler

Overview:
Sequences all unordered ball pairs (i<j) of the billiard table through one shared ball_collision_detect instance, instantiated inside this block. Reads ball positions from the position RAM through two synchronous read ports. Streams each colliding pair to the collision-response stage over a valid/ready handshake. Started once per physics frame by the frame controller.

Parameters:
N, 32, signed coordinate/radius width; passed to ball_collision_detect.
NUM_BALLS, 16, number of balls; must be >= 2.
IDX_W, 4, ball index width; must be >= clog2(NUM_BALLS).
CNT_W, 8, width of hit_count.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  begin a frame scan; sampled only in IDLE.
abort  in  1  synchronous abort; return to IDLE next cycle.
radius  in  N  ball radius; captured into radius_q when start is accepted.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the scan completes; not raised on abort.
rd_addr_a  out  IDX_W  position RAM port A address (= i).
rd_addr_b  out  IDX_W  position RAM port B address (= j).
rd_x_a, rd_y_a  in  N each  ball i position; valid 1 cycle after address.
rd_x_b, rd_y_b  in  N each  ball j position; valid 1 cycle after address.
pair_valid  out  1  colliding pair available.
pair_ready  in  1  consumer accepts pair.
pair_i, pair_j  out  IDX_W each  colliding pair indices, i<j.
hit_count  out  CNT_W  pairs emitted this scan; saturates at all-ones.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; i=0, j=1; busy=0, done=0, pair_valid=0; pair_i=0, pair_j=0; hit_count=0; radius_q=0; rd_addr_a=0, rd_addr_b=0.
- Addresses are driven from registered i/j. RAM data is valid one cycle later.
- States:
  - IDLE: on start=1 → radius_q<=radius, i<=0, j<=1, hit_count<=0, go FETCH.
  - FETCH: addresses for (i,j) stable. Next state is CHECK.
  - CHECK: RAM data valid. Detector evaluates (rd_x_a,rd_y_a) vs (rd_x_b,rd_y_b) with radius_q.
    - collides=1 → latch pair_i<=i, pair_j<=j, go EMIT.
    - collides=0 → ADVANCE.
  - EMIT: pair_valid=1, with pair_i/pair_j stable. On pair_valid & pair_ready → hit_count++ (saturating), then ADVANCE. Otherwise hold indefinitely.
  - ADVANCE (transition action, not a state):
    - if j<NUM_BALLS-1: j<=j+1, go FETCH.
    - else if i<NUM_BALLS-2: i<=i+1, j<=i+2, go FETCH.
    - else go DONE.
  - DONE: done=1 for exactly one cycle. Next state is IDLE.
- Timing:
  - Non-colliding pair costs 2 cycles; colliding pair costs 3+stall cycles.
  - Full scan without hits: start sampled at edge k → done high during cycle k+1+NUM_BALLS*(NUM_BALLS-1), i.e. 2 cycles per pair. With NUM_BALLS=4 that is cycle k+13.
- Collision test is strict: dist² < (2r)² (detector arithmetic, N-bit signed). Exactly touching balls do not collide.
- start while busy: ignored, and radius_q is unchanged.
- abort:
  - Has priority over every transition in any non-IDLE state. Next cycle: IDLE, pair_valid=0, no done pulse.
  - hit_count holds its value until the next start.
  - abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Handshake: pair_valid never drops without a handshake, except on abort or reset. pair_ready while pair_valid=0 is ignored.
- Mid-operation rst_n assertion: immediate return to reset values.
- hit_count at all-ones stays all-ones; emission is unaffected.

Test Plan:
- NUM_BALLS=4, balls at (0,0),(100,0),(0,100),(100,100), radius=10, start at edge k → no pair_valid; done pulse at cycle k+13 only; busy high k+1..k+13; hit_count=0.
- Balls 0 and 2 at (0,0),(5,0), others far, radius=10, pair_ready=1 → exactly one handshake with pair_i=0, pair_j=2; hit_count=1; done at k+14.
- All 4 balls at (0,0), pair_ready held low 5 cycles per pair → pairs (0,1),(0,2),(0,3),(1,2),(1,3),(2,3) in order; pair_i/pair_j stable while stalled; hit_count=6.
- Touching case: balls at (0,0) and (20,0), radius=10 → no collision. Same case with (19,0) → pair (0,1) emitted.
- abort asserted in EMIT while stalled → pair_valid=0 and IDLE next cycle; no done pulse. A new start rescans from (0,1) with hit_count reset to 0.
- rst_n pulled low during CHECK → all outputs at reset values immediately. start during busy is ignored; changing radius mid-scan does not alter results.

Source files
------------

// File: rtl/collision_pair_scheduler.sv
// ============================================================================
// Module   : collision_pair_scheduler (+ ball_collision_detect)
// Brief    : Walks every unordered ball pair (i<j) through one shared
//            collision detector and streams colliding pairs downstream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_collision_detect #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] x_a,
  input  logic signed [N-1:0] y_a,
  input  logic signed [N-1:0] x_b,
  input  logic signed [N-1:0] y_b,
  input  logic signed [N-1:0] radius,
  output logic                collides
);
  logic signed [N:0]     dx, dy, two_r;
  logic signed [2*N+1:0] dx_e, dy_e, two_r_e;
  logic        [2*N+1:0] dist2, lim2;

  always_comb begin
    dx      = {x_a[N-1], x_a} - {x_b[N-1], x_b};
    dy      = {y_a[N-1], y_a} - {y_b[N-1], y_b};
    two_r   = {radius, 1'b0};
    dx_e    = {{(N+1){dx[N]}}, dx};
    dy_e    = {{(N+1){dy[N]}}, dy};
    two_r_e = {{(N+1){two_r[N]}}, two_r};
    // Strict compare: exactly touching balls are not a collision.
    dist2    = (dx_e * dx_e) + (dy_e * dy_e);
    lim2     = two_r_e * two_r_e;
    collides = (dist2 < lim2);
  end
endmodule

module collision_pair_scheduler #(
  parameter int N         = 32,
  parameter int NUM_BALLS = 16,
  parameter int IDX_W     = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [N-1:0]     radius,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] rd_addr_a,
  output logic [IDX_W-1:0] rd_addr_b,
  input  logic [N-1:0]     rd_x_a,
  input  logic [N-1:0]     rd_y_a,
  input  logic [N-1:0]     rd_x_b,
  input  logic [N-1:0]     rd_y_b,
  output logic             pair_valid,
  input  logic             pair_ready,
  output logic [IDX_W-1:0] pair_i,
  output logic [IDX_W-1:0] pair_j,
  output logic [CNT_W-1:0] hit_count
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CHECK = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_J = IDX_W'(NUM_BALLS - 1);
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NUM_BALLS - 2);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  logic [IDX_W-1:0] pair_i_q, pair_i_d, pair_j_q, pair_j_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [N-1:0]     radius_q, radius_d;
  logic             collides;
  logic             advance;

  ball_collision_detect #(.N(N)) u_detect (
    .x_a      (rd_x_a),
    .y_a      (rd_y_a),
    .x_b      (rd_x_b),
    .y_b      (rd_y_b),
    .radius   (radius_q),
    .collides (collides)
  );

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    pair_i_d    = pair_i_q;
    pair_j_d    = pair_j_q;
    hit_count_d = hit_count_q;
    radius_d    = radius_q;
    advance     = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            radius_d    = radius;
            i_d         = '0;
            j_d         = IDX_W'(1);
            hit_count_d = '0;
            state_d     = S_FETCH;
          end
        end
        S_FETCH: state_d = S_CHECK;
        S_CHECK: begin
          if (collides) begin
            pair_i_d = i_q;
            pair_j_d = j_q;
            state_d  = S_EMIT;
          end else begin
            advance = 1'b1;
          end
        end
        S_EMIT: begin
          if (pair_ready) begin
            if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_W'(1);
            advance = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase

      // Row-major walk of the upper triangle: (0,1)..(0,N-1),(1,2)..
      if (advance) begin
        if (j_q < LAST_J) begin
          j_d     = j_q + IDX_W'(1);
          state_d = S_FETCH;
        end else if (i_q < LAST_I) begin
          i_d     = i_q + IDX_W'(1);
          j_d     = i_q + IDX_W'(2);
          state_d = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= IDX_W'(1);
      pair_i_q    <= '0;
      pair_j_q    <= '0;
      hit_count_q <= '0;
      radius_q    <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      pair_i_q    <= pair_i_d;
      pair_j_q    <= pair_j_d;
      hit_count_q <= hit_count_d;
      radius_q    <= radius_d;
    end
  end

  // Address port B comes from j, which resets to 1, but the RAM address
  // output must read 0 while the block is idle after reset.
  logic addr_live_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_live_q <= 1'b0;
    else if (state_d != S_IDLE) addr_live_q <= 1'b1;
  end

  assign rd_addr_a  = i_q;
  assign rd_addr_b  = addr_live_q ? j_q : '0;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign pair_valid = (state_q == S_EMIT);
  assign pair_i     = pair_i_q;
  assign pair_j     = pair_j_q;
  assign hit_count  = hit_count_q;
endmodule

`default_nettype wire

// File: tb/tb_collision_pair_scheduler.sv
// ============================================================================
// Module   : tb_collision_pair_scheduler
// Brief    : Scoreboard bench for collision_pair_scheduler with 4 balls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_collision_pair_scheduler;
  localparam int N = 32, NB = 4, IW = 4, CW = 8;

  logic          clk, rst_n, start, abort, busy, done;
  logic [N-1:0]  radius;
  logic [IW-1:0] rd_addr_a, rd_addr_b, pair_i, pair_j;
  logic [N-1:0]  rd_x_a, rd_y_a, rd_x_b, rd_y_b;
  logic          pair_valid, pair_ready;
  logic [CW-1:0] hit_count;

  collision_pair_scheduler #(.N(N), .NUM_BALLS(NB), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .radius(radius),
    .busy(busy), .done(done), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_x_a(rd_x_a), .rd_y_a(rd_y_a), .rd_x_b(rd_x_b), .rd_y_b(rd_y_b),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_i(pair_i), .pair_j(pair_j), .hit_count(hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int xm [16];
  int ym [16];
  always @(posedge clk) begin
    rd_x_a <= xm[rd_addr_a];
    rd_y_a <= ym[rd_addr_a];
    rd_x_b <= xm[rd_addr_b];
    rd_y_b <= ym[rd_addr_b];
  end

  int n_vec = 0, n_fail = 0;
  int sb[$];
  int stall_len = 0;
  bit allow_drop = 0;
  logic [CW-1:0] hc1;
  logic [IW-1:0] a1, b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Ready generator plus scoreboard monitor in one process to avoid races.
  initial begin
    int stall_cnt = 0, e;
    bit prev_stall = 0;
    logic [IW-1:0] prev_pi = '0, prev_pj = '0;
    pair_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (pair_valid) begin
        if (stall_cnt >= stall_len) pair_ready = 1'b1;
        else begin pair_ready = 1'b0; stall_cnt++; end
      end else begin
        pair_ready = 1'b0;
        stall_cnt  = 0;
      end
      if (prev_stall && !allow_drop && rst_n) begin
        chk("valid_hold", pair_valid, 1);
        chk("pair_i_hold", pair_i, prev_pi);
        chk("pair_j_hold", pair_j, prev_pj);
      end
      if (pair_valid && pair_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL unexpected_pair: got (%0d,%0d) expected none", pair_i, pair_j);
        end else begin
          e = sb.pop_front();
          chk("pair_i", pair_i, e / 16);
          chk("pair_j", pair_j, e % 16);
        end
      end
      prev_stall = pair_valid && !pair_ready;
      prev_pi    = pair_i;
      prev_pj    = pair_j;
    end
  end

  task automatic set_balls(input int x0, y0, x1, y1, x2, y2, x3, y3);
    xm[0] = x0; ym[0] = y0; xm[1] = x1; ym[1] = y1;
    xm[2] = x2; ym[2] = y2; xm[3] = x3; ym[3] = y3;
  endtask

  task automatic start_scan(input int r);
    @(negedge clk);
    start  = 1'b1;
    radius = r;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the edge that accepted start.
  task automatic wait_done(input int exp_cyc, input int exp_hits, input int pulse_at, input string tag);
    int  cyc = 0, done_cyc = -1;
    bit  busy_ok = 1;
    while (cyc < 300 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin hc1 = hit_count; a1 = rd_addr_a; b1 = rd_addr_b; end
      if (!busy) busy_ok = 0;
      if (done) done_cyc = cyc;
      if (cyc == pulse_at) begin start = 1'b1; radius = 100; end
      else start = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, done_cyc, exp_cyc);
    chk({tag, "_busy_window"}, busy_ok, 1);
    @(negedge clk);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_width"}, done, 0);
    chk({tag, "_hit_count"}, hit_count, exp_hits);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    int w;
    int done_seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; radius = '0;
    for (int k = 0; k < 16; k++) begin xm[k] = 5000 + 3000 * k; ym[k] = 0; end
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", pair_valid, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_addr_a", rd_addr_a, 0);
    chk("rst_addr_b", rd_addr_b, 0);
    chk("rst_pair_i", pair_i, 0);
    chk("rst_pair_j", pair_j, 0);
    rst_n = 1'b1;

    // Square of far-apart balls: no collisions.
    stall_len = 0;
    set_balls(0, 0, 100, 0, 0, 100, 100, 100);
    start_scan(10);
    wait_done(13, 0, 0, "nohit");

    // Balls 0 and 2 overlap.
    set_balls(0, 0, 1000, 0, 5, 0, 0, 1000);
    sb.push_back(0 * 16 + 2);
    start_scan(10);
    wait_done(14, 1, 0, "one_hit");

    // All coincident, 5-cycle stall per pair: 6 pairs at 8 cycles each.
    set_balls(0, 0, 0, 0, 0, 0, 0, 0);
    stall_len = 5;
    for (int a = 0; a < 3; a++)
      for (int b = a + 1; b < 4; b++) sb.push_back(a * 16 + b);
    start_scan(10);
    wait_done(49, 6, 0, "all_stall");
    stall_len = 0;

    // Exactly touching (distance 2r) is not a collision; one less is.
    set_balls(0, 0, 20, 0, 1000, 1000, -1000, 1000);
    start_scan(10);
    wait_done(13, 0, 0, "touch");
    set_balls(0, 0, 19, 0, 1000, 1000, -1000, 1000);
    sb.push_back(0 * 16 + 1);
    start_scan(10);
    wait_done(14, 1, 0, "overlap1");

    // Abort while stalled on the second pair.
    set_balls(0, 0, 0, 0, 0, 0, 0, 0);
    sb.push_back(0 * 16 + 1);
    start_scan(10);
    w = 0;
    while (hit_count != 1 && w < 50) begin @(negedge clk); w++; end
    chk("abort_first_hit", hit_count, 1);
    stall_len = 1000;
    w = 0;
    while (!pair_valid && w < 50) begin @(negedge clk); w++; end
    chk("abort_reach_emit", pair_valid, 1);
    chk("abort_pending_j", pair_j, 2);
    repeat (2) @(negedge clk);
    allow_drop = 1;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", pair_valid, 0);
    chk("abort_busy", busy, 0);
    done_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_hits_hold", hit_count, 1);
    chk("abort_sb_empty", sb.size(), 0);
    allow_drop = 0;
    stall_len  = 0;

    // Fresh scan restarts at (0,1) with counter cleared.
    for (int a = 0; a < 3; a++)
      for (int b = a + 1; b < 4; b++) sb.push_back(a * 16 + b);
    start_scan(10);
    wait_done(19, 6, 0, "rescan");
    chk("rescan_hits_c1", hc1, 0);
    chk("rescan_addr_a_c1", a1, 0);
    chk("rescan_addr_b_c1", b1, 1);

    // Asynchronous reset while in CHECK.
    start_scan(10);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_valid", pair_valid, 0);
    chk("midrst_pair_i", pair_i, 0);
    chk("midrst_pair_j", pair_j, 0);
    chk("midrst_hits", hit_count, 0);
    chk("midrst_addr_a", rd_addr_a, 0);
    chk("midrst_addr_b", rd_addr_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start pulse with a larger radius mid-scan is ignored.
    set_balls(0, 0, 19, 0, 150, 0, 0, 1000);
    sb.push_back(0 * 16 + 1);
    start_scan(10);
    wait_done(14, 1, 4, "busy_start");

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

`default_nettype wire
